// File: rtl/rename_ckpt_pkg.sv
// Shared types and sizing for the register renamer with branch checkpoints.
// Contents:
//   NUM_ARCH_REG / NUM_PHYS_REG / NUM_CKPT  - sizing
//   AW / PW / CW                            - index widths derived from the sizes
//   lut_t                                   - one full arch->phys map
//   ckpt_entry_t                            - checkpoint {map snapshot, free-list read pointer}
//   rn_req_t / rn_rsp_t                     - rename request / response bundles
package rename_ckpt_pkg;

    localparam int NUM_ARCH_REG = 16;
    localparam int NUM_PHYS_REG = 128;
    localparam int NUM_CKPT     = 4;

    // Index width of an n-entry table; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int AW      = idx_w(NUM_ARCH_REG);
    localparam int PW      = idx_w(NUM_PHYS_REG);
    localparam int CW      = idx_w(NUM_CKPT);
    localparam int FL_INIT = NUM_PHYS_REG - NUM_ARCH_REG;

    typedef logic [AW-1:0] areg_t;
    typedef logic [PW-1:0] preg_t;
    typedef logic [PW:0]   fl_ptr_t;
    typedef logic [CW-1:0] ctag_t;

    typedef preg_t [NUM_ARCH_REG-1:0] lut_t;

    typedef struct packed {
        lut_t    lut;
        fl_ptr_t rd_ptr;
    } ckpt_entry_t;

    typedef struct packed {
        logic  w_v;
        logic  is_branch;
        areg_t src1;
        areg_t src2;
        areg_t dest;
    } rn_req_t;

    typedef struct packed {
        preg_t psrc1;
        preg_t psrc2;
        preg_t pdest;
        preg_t pfreed;
        ctag_t ckpt_tag;
    } rn_rsp_t;

endpackage

// File: rtl/rename_ckpt_fifo.sv
// Snapshot FIFO holding one checkpoint per in-flight branch.
// Ports:
//   clk_i, reset_i     - clock, synchronous active-high reset
//   push_i/push_data_i - append a snapshot at the tail
//   pop_i              - retire the head entry (correctly predicted branch)
//   restore_i          - drop every entry younger than head, head included (tail = head)
//   clear_i            - empty the FIFO
//   head_data_o        - snapshot at the head
//   count_o            - live entries (tail - head)
//   head_tag_o         - index of the head entry (tag of the oldest branch)
//   tail_tag_o         - index the next push will use (tag given to a new branch)
// Priority: clear_i > restore_i > pop_i/push_i. Push and pop may share a cycle.
module rename_ckpt_fifo
    import rename_ckpt_pkg::*;
#(
    parameter int  DEPTH   = NUM_CKPT,
    parameter type entry_t = ckpt_entry_t
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      push_i,
    input  entry_t                    push_data_i,
    input  logic                      pop_i,
    input  logic                      restore_i,
    input  logic                      clear_i,
    output entry_t                    head_data_o,
    output logic [idx_w(DEPTH):0]     count_o,
    output logic [idx_w(DEPTH)-1:0]   head_tag_o,
    output logic [idx_w(DEPTH)-1:0]   tail_tag_o
);

    localparam int IW = idx_w(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [IW:0]   head_q, head_d;
    logic [IW:0]   tail_q, tail_d;
    logic          push_en;

    assign push_en = push_i & ~clear_i & ~restore_i;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (clear_i || restore_i) begin
            tail_d = head_q;
        end else begin
            if (pop_i)   head_d = head_q + 1'b1;
            if (push_en) tail_d = tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Snapshot storage needs no reset: entries are only read while live.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[tail_q[IW-1:0]] <= push_data_i;
    end

    assign head_data_o = mem_q[head_q[IW-1:0]];
    assign count_o     = tail_q - head_q;
    assign head_tag_o  = head_q[IW-1:0];
    assign tail_tag_o  = tail_q[IW-1:0];

endmodule

// File: rtl/rename_ckpt_unit.sv
// Single-issue register renamer with per-branch map checkpoints.
// A mispredict restores the speculative map and free-list read pointer in one
// cycle from the mispredicted branch's checkpoint; a flush restores from the
// committed map.
// Ports:
//   clk_i, reset_i                        - clock, synchronous active-high reset
//   rn_*_i / rn_ready_o                   - rename request and handshake
//   rn_psrc1_o, rn_psrc2_o, rn_pdest_o,
//   rn_pfreed_o, rn_ckpt_tag_o            - combinational rename response
//   commit_*_i                            - ROB commit: arch map update + free
//   br_resolve_v_i, br_tag_i,
//   br_mispredict_i                       - in-order branch resolution
//   flush_i                               - full pipeline flush
//   fl_count_o, ckpt_count_o              - free registers / live checkpoints
module rename_ckpt_unit
    import rename_ckpt_pkg::*;
(
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          rn_v_i,
    output logic          rn_ready_o,
    input  logic [AW-1:0] rn_src1_i,
    input  logic [AW-1:0] rn_src2_i,
    input  logic [AW-1:0] rn_dest_i,
    input  logic          rn_w_v_i,
    input  logic          rn_is_branch_i,
    output logic [PW-1:0] rn_psrc1_o,
    output logic [PW-1:0] rn_psrc2_o,
    output logic [PW-1:0] rn_pdest_o,
    output logic [PW-1:0] rn_pfreed_o,
    output logic [CW-1:0] rn_ckpt_tag_o,
    input  logic          commit_v_i,
    input  logic          commit_w_v_i,
    input  logic [AW-1:0] commit_arch_i,
    input  logic [PW-1:0] commit_preg_i,
    input  logic [PW-1:0] commit_freed_i,
    input  logic          br_resolve_v_i,
    input  logic [CW-1:0] br_tag_i,
    input  logic          br_mispredict_i,
    input  logic          flush_i,
    output logic [PW:0]   fl_count_o,
    output logic [CW:0]   ckpt_count_o
);

    lut_t        spec_lut_q, spec_lut_d, spec_lut_upd;
    lut_t        arch_lut_q, arch_lut_d;
    preg_t       fl_q [NUM_PHYS_REG];
    fl_ptr_t     rd_ptr_q, rd_ptr_d, rd_ptr_upd;
    fl_ptr_t     commit_rd_ptr_q, commit_rd_ptr_d;
    fl_ptr_t     wr_ptr_q, wr_ptr_d;

    rn_req_t     req;
    rn_rsp_t     rsp;
    logic        mispredict, fire, alloc, commit_fire;
    preg_t       fl_head;
    fl_ptr_t     fl_count;
    ckpt_entry_t ckpt_push, ckpt_head;
    logic [CW:0] ckpt_count;
    ctag_t       ckpt_head_tag, ckpt_tail_tag;

    assign req = '{w_v: rn_w_v_i, is_branch: rn_is_branch_i,
                   src1: rn_src1_i, src2: rn_src2_i, dest: rn_dest_i};

    assign mispredict  = br_resolve_v_i & br_mispredict_i;
    assign fl_count    = wr_ptr_q - rd_ptr_q;
    assign commit_fire = commit_v_i & commit_w_v_i;

    // Ready ignores rn_v_i and conservatively drops on any recovery cycle.
    assign rn_ready_o = ~flush_i & ~mispredict & (fl_count != '0)
                      & (ckpt_count != (CW+1)'(NUM_CKPT));
    assign fire    = rn_v_i & rn_ready_o;
    assign alloc   = fire & req.w_v;
    assign fl_head = fl_q[rd_ptr_q[PW-1:0]];

    // Sources and the freed mapping come from the pre-update map, so a
    // source equal to the destination still sees the old mapping.
    assign rsp.psrc1    = spec_lut_q[req.src1];
    assign rsp.psrc2    = spec_lut_q[req.src2];
    assign rsp.pfreed   = spec_lut_q[req.dest];
    assign rsp.pdest    = req.w_v ? fl_head : preg_t'(req.dest);
    assign rsp.ckpt_tag = ckpt_tail_tag;

    assign rn_psrc1_o    = rsp.psrc1;
    assign rn_psrc2_o    = rsp.psrc2;
    assign rn_pdest_o    = rsp.pdest;
    assign rn_pfreed_o   = rsp.pfreed;
    assign rn_ckpt_tag_o = rsp.ckpt_tag;

    always_comb begin
        spec_lut_upd = spec_lut_q;
        if (alloc) spec_lut_upd[req.dest] = fl_head;
        rd_ptr_upd = rd_ptr_q + {{PW{1'b0}}, alloc};

        arch_lut_d      = arch_lut_q;
        commit_rd_ptr_d = commit_rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        if (commit_fire) begin
            arch_lut_d[commit_arch_i] = commit_preg_i;
            commit_rd_ptr_d           = commit_rd_ptr_q + 1'b1;
            wr_ptr_d                  = wr_ptr_q + 1'b1;
        end

        // Flush sees this cycle's commit so the restored map is current.
        if (flush_i) begin
            spec_lut_d = arch_lut_d;
            rd_ptr_d   = commit_rd_ptr_d;
        end else if (mispredict) begin
            spec_lut_d = ckpt_head.lut;
            rd_ptr_d   = ckpt_head.rd_ptr;
        end else begin
            spec_lut_d = spec_lut_upd;
            rd_ptr_d   = rd_ptr_upd;
        end
    end

    // The branch's own destination update is part of its checkpoint.
    assign ckpt_push = '{lut: spec_lut_upd, rd_ptr: rd_ptr_upd};

    rename_ckpt_fifo #(
        .DEPTH   (NUM_CKPT),
        .entry_t (ckpt_entry_t)
    ) u_ckpt_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (fire & req.is_branch),
        .push_data_i (ckpt_push),
        .pop_i       (br_resolve_v_i & ~br_mispredict_i),
        .restore_i   (mispredict),
        .clear_i     (flush_i),
        .head_data_o (ckpt_head),
        .count_o     (ckpt_count),
        .head_tag_o  (ckpt_head_tag),
        .tail_tag_o  (ckpt_tail_tag)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_ARCH_REG; i++) begin
                spec_lut_q[i] <= preg_t'(i);
                arch_lut_q[i] <= preg_t'(i);
            end
            rd_ptr_q        <= '0;
            commit_rd_ptr_q <= '0;
            wr_ptr_q        <= fl_ptr_t'(FL_INIT);
        end else begin
            spec_lut_q      <= spec_lut_d;
            arch_lut_q      <= arch_lut_d;
            rd_ptr_q        <= rd_ptr_d;
            commit_rd_ptr_q <= commit_rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_PHYS_REG; i++) begin
                fl_q[i] <= (i < FL_INIT) ? preg_t'(i + NUM_ARCH_REG) : '0;
            end
        end else if (commit_fire) begin
            fl_q[wr_ptr_q[PW-1:0]] <= commit_freed_i;
        end
    end

    assign fl_count_o   = fl_count;
    assign ckpt_count_o = ckpt_count;

    a_resolve_in_order: assert property (@(posedge clk_i) disable iff (reset_i)
        br_resolve_v_i |-> (ckpt_count != '0) && (br_tag_i == ckpt_head_tag));

    a_fl_count_bound: assert property (@(posedge clk_i) disable iff (reset_i)
        fl_count <= fl_ptr_t'(FL_INIT));

endmodule
